pong_paddle_ctrl: RTL
=====================

# pong_paddle_ctrl

Per-player paddle position conditioner sitting directly upstream of the `pong` core's `paddle1_vpos` / `paddle2_vpos` inputs. It is instantiated twice in `emu`, once per player.

Each instance does four things:
- selects the position source (analog Y, analog X, inverted X, or a paddle controller);
- slew-limits the position;
- latches the result once per frame on the rising edge of `vsync`, so the paddle never tears mid-frame;
- optionally lets digital up/down inputs ramp the paddle.

## Interface
Parameters:
- `SLEW`, default 16: maximum analog-driven change of `vpos` per frame, range 1..255.
- `STEP`, default 4: digital ramp increment per frame.
- `DEADBAND`, default 8: analog movement, relative to the snapshot, that returns control from digital to analog.

Ports:
- `clk_sys`  in  1  system clock (7.159 MHz).
- `reset`  in  1  synchronous, active-high reset.
- `vsync`  in  1  active-high vertical sync from `pong`; its rising edge is the frame tick.
- `mode`  in  2  source select: 0 = Y, 1 = X, 2 = Inv-X, 3 = Paddle.
- `analog`  in  16  `{Y[15:8], X[7:0]}`, signed two's complement.
- `paddle`  in  8  unsigned paddle position.
- `joy_up`  in  1  digital up (active-high).
- `joy_down`  in  1  digital down (active-high).
- `vpos`  out  8  conditioned paddle position for `pong`.
- `digital_active`  out  1  high while the digital ramp owns `vpos`.

## Operation
Target (combinational, registered inputs not required):
- mode 0: `Y + 8'h80`
- mode 1: `X + 8'h80`
- mode 2: `X ^ 8'h7F`
- mode 3: `paddle`
- All arithmetic is 8-bit and wraps modulo 256.

Frame tick:
- `tick = vsync & ~vs_q`, where `vs_q` is `vsync` registered.
- All state and output updates below occur only on a tick.

Mode change:
- `mode_q` latches `mode` at each tick.
- If `mode != mode_q` at a tick: `vpos <= target`, with no slew; state goes to ANALOG; snapshot is updated.

State ANALOG:
- Compute 9-bit signed `diff = target - vpos`.
- If `|diff| <= SLEW`: `vpos <= target`; otherwise `vpos <= vpos ± SLEW`. This never wraps.
- If exactly one of `joy_up` / `joy_down` is high: go to DIGITAL, and set `snap <= target`. `vpos` is held this tick and not slewed.

State DIGITAL:
- `joy_up` only: `vpos <= min(vpos + STEP, 255)`.
- `joy_down` only: `vpos <= max(vpos - STEP, 0)`.
- Both or neither: hold.
- Saturation arithmetic is done in 9 bits.
- If `|target - snap| > DEADBAND`: go to ANALOG. No movement this tick; slew resumes next tick.

`digital_active = (state == DIGITAL)`, registered.

## Timing
Reset values:
- `vpos = 8'h80`
- `digital_active = 0`
- state ANALOG
- `vs_q = 0`
- `mode_q = 0`
- `snap = 8'h80`

Reset is sampled on `clk_sys`. Reset mid-frame discards any pending tick. The first tick after reset with `mode != 0` applies the mode-change jump.

Latency:
- `vsync` high at edge n with `vs_q == 0` gives `vpos` / `digital_active` new values visible after edge n+1 (one-cycle latency from the sampled rising edge).
- Between ticks, outputs are stable for the entire frame regardless of input activity.
- A `vsync` held high produces a single tick. A glitch pulse of one cycle still counts as a tick.
- Priority per tick: `reset` > mode change > state logic.

## Configuration
`PONG_PADDLE_DIGITAL_EN`:
- Defined: DIGITAL state and `joy_up` / `joy_down` handling are compiled in, as described above.
- Undefined: `joy_up` / `joy_down` are ignored, the state is fixed at ANALOG, `digital_active` is tied 0, and the `STEP` / `DEADBAND` parameters are unused.

## Structure
- Package `pong_paddle_pkg` holds:
  - mode enum `MODE_Y`, `MODE_X`, `MODE_INVX`, `MODE_PADDLE`;
  - state enum `ST_ANALOG`, `ST_DIGITAL`;
  - `VPOS_CENTER = 8'h80`.
- One sub-module, `pong_paddle_slew`: combinational one-step limiter with inputs `cur[7:0]`, `tgt[7:0]`, parameter `SLEW`, and output `nxt[7:0]`.
- `emu` drives `mode` from `status[10:9]` / `status[12:11]`.

## Test plan
- Reset, then mode 0, `analog = 16'h0000`: `vpos = 8'h80` with `digital_active = 0` after reset, and it stays `8'h80` after ticks.
- Mode 0, Y = `8'h7F` (target `8'hFF`), starting from `8'h80`, `SLEW = 16`: `vpos` goes `90`, `A0`, … , `F0`, `FF`, reaching `FF` on the 8th tick.
- Mode switch from 0 to 3 with `paddle = 8'h20` and `vpos = 8'hFF`: `vpos = 8'h20` on the next tick (jump, no slew).
- Macro defined, mode 3, `paddle = 8'h80`, `joy_up` held for 3 ticks:
  - tick 1: `digital_active = 1`, `vpos = 8'h80`;
  - ticks 2–3: `84`, `88`;
  - then `paddle = 8'h90`: next tick `digital_active = 0`, following tick `vpos = 8'h90`.
- Digital saturation: `vpos = 8'hFE`, `joy_up` gives `FF` and holds at `FF`. Both `joy_up` and `joy_down` high: `vpos` unchanged.
- `vsync` held high for 500 cycles: exactly one update. `reset` asserted one cycle after a rising edge: `vpos = 8'h80`, with no update from that edge.

Source files
------------

// File: rtl/pong_paddle_pkg.sv
// -----------------------------------------------------------------------------
// pong_paddle_pkg
// Shared types and constants for the per-player paddle conditioner.
//   mode_t      : position source select (Y, X, inverted X, paddle controller)
//   state_t     : ownership of vpos (analog slew path or digital ramp)
//   VPOS_CENTER : mid-screen paddle position used at reset
// -----------------------------------------------------------------------------
package pong_paddle_pkg;

  typedef enum logic [1:0] {
    MODE_Y      = 2'd0,
    MODE_X      = 2'd1,
    MODE_INVX   = 2'd2,
    MODE_PADDLE = 2'd3
  } mode_t;

  typedef enum logic {
    ST_ANALOG  = 1'b0,
    ST_DIGITAL = 1'b1
  } state_t;

  localparam logic [7:0] VPOS_CENTER = 8'h80;

endpackage

// File: rtl/pong_paddle_slew.sv
// -----------------------------------------------------------------------------
// pong_paddle_slew
// Combinational one-step limiter: moves cur toward tgt by at most SLEW.
// Parameters:
//   SLEW : maximum step size, 1..255
// Ports:
//   cur [7:0] in  : present position
//   tgt [7:0] in  : desired position
//   nxt [7:0] out : next position (never overshoots tgt, never wraps)
// -----------------------------------------------------------------------------
module pong_paddle_slew #(
  parameter int SLEW = 16
) (
  input  logic [7:0] cur,
  input  logic [7:0] tgt,
  output logic [7:0] nxt
);

  localparam logic signed [8:0] SLEW_S = 9'(SLEW);
  localparam logic [7:0]        SLEW_U = 8'(SLEW);

  logic signed [8:0] diff;

  always_comb begin
    // Both operands are zero-extended, so the 9-bit difference is exact.
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    nxt  = tgt;
    if (diff > SLEW_S) begin
      nxt = cur + SLEW_U;
    end else if (diff < -SLEW_S) begin
      nxt = cur - SLEW_U;
    end
  end

endmodule

// File: rtl/pong_paddle_ctrl.sv
// -----------------------------------------------------------------------------
// pong_paddle_ctrl
// Per-player paddle position conditioner feeding pong's paddleN_vpos.
// Selects a position source, slew-limits it, and updates only once per frame
// (rising edge of vsync) so the paddle never tears mid-frame.
//
// Optional feature macro: PONG_PADDLE_DIGITAL_EN
//   defined   : joy_up/joy_down can take over and ramp vpos (DIGITAL state)
//   undefined : joystick ignored, always ANALOG, digital_active tied 0
//
// Parameters:
//   SLEW     : max analog-driven vpos change per frame (1..255)
//   STEP     : digital ramp increment per frame
//   DEADBAND : analog movement (vs. snapshot) that hands control back to analog
// Ports:
//   clk_sys        in  : system clock
//   reset          in  : synchronous active-high reset
//   vsync          in  : vertical sync, rising edge is the frame tick
//   mode [1:0]     in  : 0=Y, 1=X, 2=Inv-X, 3=Paddle
//   analog [15:0]  in  : {Y, X}, signed
//   paddle [7:0]   in  : unsigned paddle position
//   joy_up         in  : digital up
//   joy_down       in  : digital down
//   vpos [7:0]     out : conditioned paddle position
//   digital_active out : high while the digital ramp owns vpos
// -----------------------------------------------------------------------------
module pong_paddle_ctrl
  import pong_paddle_pkg::*;
#(
  parameter int SLEW     = 16,
  parameter int STEP     = 4,
  parameter int DEADBAND = 8
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        vsync,
  input  logic [1:0]  mode,
  input  logic [15:0] analog,
  input  logic [7:0]  paddle,
  input  logic        joy_up,
  input  logic        joy_down,
  output logic [7:0]  vpos,
  output logic        digital_active
);

  logic        vs_q;
  logic        tick_p1;
  mode_t       mode_q;
  logic [7:0]  target;
  logic [7:0]  slew_nxt;
  logic [7:0]  vpos_nxt;
  logic        mode_chg;

  assign mode_chg = (mode_t'(mode) != mode_q);

  always_comb begin
    target = paddle;
    unique case (mode_t'(mode))
      MODE_Y:      target = analog[15:8] + 8'h80;
      MODE_X:      target = analog[7:0] + 8'h80;
      MODE_INVX:   target = analog[7:0] ^ 8'h7F;
      MODE_PADDLE: target = paddle;
    endcase
  end

  pong_paddle_slew #(
    .SLEW (SLEW)
  ) u_slew (
    .cur (vpos),
    .tgt (target),
    .nxt (slew_nxt)
  );

  // Edge detect: vsync sampled at edge n registers tick_p1, the update lands
  // at edge n+1. Reset clears tick_p1 so a pending tick is discarded.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      vs_q    <= 1'b0;
      tick_p1 <= 1'b0;
      mode_q  <= MODE_Y;
      vpos    <= VPOS_CENTER;
    end else begin
      vs_q    <= vsync;
      tick_p1 <= vsync & ~vs_q;
      if (tick_p1) begin
        mode_q <= mode_t'(mode);
        vpos   <= vpos_nxt;
      end
    end
  end

`ifdef PONG_PADDLE_DIGITAL_EN

  localparam logic [8:0] STEP9     = 9'(STEP);
  localparam logic [8:0] DEADBAND9 = 9'(DEADBAND);

  state_t          state;
  state_t          state_nxt;
  logic [7:0]      snap;
  logic [7:0]      snap_nxt;
  logic signed [8:0] snap_diff;
  logic [8:0]      snap_dist;

  function automatic logic [7:0] ramp_up_sat(input logic [7:0] v);
    logic [8:0] s;
    s = {1'b0, v} + STEP9;
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  function automatic logic [7:0] ramp_down_sat(input logic [7:0] v);
    logic [8:0] s;
    s = {1'b0, v} - STEP9;
    // Borrow out of the 9-bit subtract means the result went below zero.
    return s[8] ? 8'h00 : s[7:0];
  endfunction

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= ST_ANALOG;
      snap  <= VPOS_CENTER;
    end else if (tick_p1) begin
      state <= state_nxt;
      snap  <= snap_nxt;
    end
  end

  always_comb begin
    snap_diff = $signed({1'b0, target}) - $signed({1'b0, snap});
    snap_dist = snap_diff[8] ? 9'(-snap_diff) : 9'(snap_diff);
  end

  always_comb begin
    state_nxt = state;
    snap_nxt  = snap;
    vpos_nxt  = vpos;
    if (mode_chg) begin
      vpos_nxt  = target;
      state_nxt = ST_ANALOG;
      snap_nxt  = target;
    end else begin
      unique case (state)
        ST_ANALOG: begin
          if (joy_up ^ joy_down) begin
            // Hand-over tick: vpos holds, snapshot records the analog target.
            state_nxt = ST_DIGITAL;
            snap_nxt  = target;
          end else begin
            vpos_nxt = slew_nxt;
          end
        end
        ST_DIGITAL: begin
          if (snap_dist > DEADBAND9) begin
            state_nxt = ST_ANALOG;
          end else if (joy_up && !joy_down) begin
            vpos_nxt = ramp_up_sat(vpos);
          end else if (joy_down && !joy_up) begin
            vpos_nxt = ramp_down_sat(vpos);
          end
        end
      endcase
    end
  end

  assign digital_active = (state == ST_DIGITAL);

`else

  logic unused_joy;
  assign unused_joy = joy_up ^ joy_down;

  // STEP and DEADBAND only shape the digital ramp; this empty block keeps
  // them referenced when that path is compiled out.
  if (STEP < 0 || DEADBAND < 0) begin : g_digital_params_idle
  end

  always_comb begin
    vpos_nxt = mode_chg ? target : slew_nxt;
  end

  assign digital_active = 1'b0;

`endif

endmodule
